// File: rtl/scsi_port_arbiter.sv
// Arbitrates CPU and DMA access to a SCSI chip register port and times CS_/RE_/WE_.
// Optional macro SCSI_WAIT_EXTEND_EN adds a WAIT input that stretches the final strobe cycle.
module scsi_port_arbiter #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic CPU_REQ,
    input  logic CPU_RW,
    input  logic DMA_REQ,
    input  logic DMA_RW,
`ifdef SCSI_WAIT_EXTEND_EN
    input  logic WAIT,
`endif
    output logic CPU_DSK_,
    output logic DMA_ACK,
    output logic SCSI_CS_,
    output logic SCSI_RE_,
    output logic SCSI_WE_,
    output logic LATCH_EN,
    output logic OWNER,
    output logic BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_CPU_END
    } state_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;          // 1 = DMA was served last
    logic       cpu_drop_q, cpu_drop_d;
    logic       dma_ack_q, dma_ack_d;

    logic       wait_hold;
    logic       cpu_go;
    logic       dma_go;
    logic       pick_dma;

`ifdef SCSI_WAIT_EXTEND_EN
    assign wait_hold = WAIT;
`else
    assign wait_hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cpu_drop_d = cpu_drop_q;
        dma_ack_d  = 1'b0;
        // DMA_REQ is still high while its acknowledge is out; do not re-grant it then.
        cpu_go     = CPU_REQ;
        dma_go     = DMA_REQ && !dma_ack_q;
        pick_dma   = dma_go && (!cpu_go || !last_q);

        case (state_q)
            ST_IDLE: begin
                if (cpu_go || dma_go) begin
                    owner_d    = pick_dma;
                    rw_d       = pick_dma ? DMA_RW : CPU_RW;
                    cnt_d      = SETUP_LOAD;
                    cpu_drop_d = 1'b0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!owner_q && !CPU_REQ) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d   = STROBE_LOAD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (!owner_q && !CPU_REQ) cpu_drop_d = 1'b1;
                if (cnt_q == '0) begin
                    if (!wait_hold) begin
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (!owner_q && !CPU_REQ) cpu_drop_d = 1'b1;
                if (cnt_q == '0) begin
                    last_d = owner_q;
                    if (owner_q) begin
                        dma_ack_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (cpu_drop_q || !CPU_REQ) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CPU_END;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CPU_END: begin
                if (!CPU_REQ) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cpu_drop_q <= 1'b0;
            dma_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cpu_drop_q <= cpu_drop_d;
            dma_ack_q  <= dma_ack_d;
        end
    end

    logic selected;
    logic strobing;

    assign selected = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    assign strobing = (state_q == ST_STROBE);

    assign SCSI_CS_ = !selected;
    assign SCSI_RE_ = !(strobing && rw_q);
    assign SCSI_WE_ = !(strobing && !rw_q);
    assign LATCH_EN = strobing && rw_q && (cnt_q == '0);
    assign CPU_DSK_ = !(state_q == ST_CPU_END);
    assign DMA_ACK  = dma_ack_q;
    assign OWNER    = owner_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule
